tdc_thermo_decoder: RTL and testbench

TDC_THERMO_DECODER -- requirements
Module: tdc_thermo_decoder

---
 rtl/tdc_thermo_decoder.sv | 169 ++++++++++++++++
 tb/tb_tdc_thermo_decoder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_thermo_decoder.sv
// Thermometer-code TDC decoder: arms on an empty delay line, captures the
// first hit word, and outputs its bubble-corrected ones count together with the
// coarse timestamp of the sampling cycle through a three-stage pipeline with
// a one-entry valid/ready output register.
// Optional build macro: TDC_BUBBLE_FILTER_EN (3-tap majority filter on therm).
module tdc_thermo_decoder #(
  parameter int N        = 32,
  parameter int COARSE_W = 16,
  parameter int FW       = $clog2(N + 1)
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                enable,
  input  logic [N-1:0]        therm,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [FW-1:0]       out_fine,
  output logic [COARSE_W-1:0] out_coarse,
  output logic                out_sat,
  output logic                overflow,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DEAD  = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [COARSE_W-1:0] coarse_q;
  logic [N-1:0]        filt;
  logic                therm_zero;
  logic                hit;

  logic                vld_p1;
  logic [N-1:0]        word_p1;
  logic [COARSE_W-1:0] coarse_p1;

  logic                vld_p2;
  logic [FW-1:0]       fine_p2;
  logic                sat_p2;
  logic [COARSE_W-1:0] coarse_p2;

  logic                load;
  logic                drop;

  // Number of set bits in the captured word (0..N).
  function automatic logic [FW-1:0] popcount(input logic [N-1:0] w);
    logic [FW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + FW'(w[i]);
    end
    return c;
  endfunction

  // Chain saturated: every tap of the delay line was reached.
  function automatic logic is_full(input logic [FW-1:0] c);
    return c == FW'(N);
  endfunction

  assign therm_zero = (therm == '0);

`ifdef TDC_BUBBLE_FILTER_EN
  // Virtual taps: below bit 0 the chain is always "reached", above bit N-1 never.
  logic [N+1:0] ext;
  assign ext = {1'b0, therm, 1'b1};

  // Three-tap majority vote removes isolated bubbles in the thermometer code.
  always_comb begin
    filt = '0;
    for (int i = 0; i < N; i++) begin
      filt[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    end
  end
`else
  assign filt = therm;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (clear) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: re-arm only after the line has fully emptied.
  always_comb begin
    state_d = state_q;
    if (enable) begin
      case (state_q)
        IDLE:    if (therm_zero) state_d = ARMED;
        ARMED:   if (filt[0])    state_d = DEAD;
        DEAD:    if (therm_zero) state_d = ARMED;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: hit strobe and debug state.
  always_comb begin
    hit   = enable && (state_q == ARMED) && filt[0];
    state = state_q;
  end

  // Free-running coarse timestamp, frozen while enable is low.
  always_ff @(posedge clk) begin
    if (clear)       coarse_q <= '0;
    else if (enable) coarse_q <= coarse_q + COARSE_W'(1);
  end

  // ---- stage 1: capture filtered word and timestamp ----
  // Stage-1 valid follows the hit strobe.
  always_ff @(posedge clk) begin
    if (clear)       vld_p1 <= 1'b0;
    else if (enable) vld_p1 <= hit;
  end

  // Stage-1 data.
  always_ff @(posedge clk) begin
    if (enable) begin
      word_p1   <= filt;
      coarse_p1 <= coarse_q;
    end
  end

  // ---- stage 2: popcount and saturation flag ----
  // Stage-2 valid.
  always_ff @(posedge clk) begin
    if (clear)       vld_p2 <= 1'b0;
    else if (enable) vld_p2 <= vld_p1;
  end

  // Stage-2 data.
  always_ff @(posedge clk) begin
    if (enable) begin
      fine_p2   <= popcount(word_p1);
      sat_p2    <= is_full(popcount(word_p1));
      coarse_p2 <= coarse_p1;
    end
  end

  // ---- stage 3: one-entry output register ----
  assign load = enable && vld_p2 && (!out_valid || out_ready);
  assign drop = enable && vld_p2 && out_valid && !out_ready;

  // Output register: held result has priority, a colliding result is dropped.
  always_ff @(posedge clk) begin
    if (clear) begin
      out_valid  <= 1'b0;
      out_fine   <= '0;
      out_coarse <= '0;
      out_sat    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (load) begin
        out_valid  <= 1'b1;
        out_fine   <= fine_p2;
        out_coarse <= coarse_p2;
        out_sat    <= sat_p2;
      end else if (out_valid && out_ready) begin
        out_valid  <= 1'b0;
      end
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tdc_thermo_decoder.sv
// Self-checking bench for tdc_thermo_decoder: directed vector table,
// hand-written overflow / clear / wrap sequences, then random traffic
// against a transaction-level reference model.
module tb_tdc_thermo_decoder;
  localparam int N  = 32;
  localparam int CW = 16;
  localparam int FW = 6;
`ifdef TDC_BUBBLE_FILTER_EN
  localparam int BUB_FINE = 8;
`else
  localparam int BUB_FINE = 7;
`endif

  logic          clk = 1'b0;
  logic          clear = 1'b1;
  logic          enable = 1'b0;
  logic [N-1:0]  therm = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [FW-1:0] out_fine;
  logic [CW-1:0] out_coarse;
  logic          out_sat;
  logic          overflow;
  logic [1:0]    state;

  int n_checks = 0;
  int n_errors = 0;

  tdc_thermo_decoder #(.N(N), .COARSE_W(CW), .FW(FW)) dut (
    .clk(clk), .clear(clear), .enable(enable), .therm(therm),
    .out_ready(out_ready), .out_valid(out_valid), .out_fine(out_fine),
    .out_coarse(out_coarse), .out_sat(out_sat), .overflow(overflow),
    .state(state)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct { int rem; int fine; int crs; bit sat; } pend_t;
  pend_t pq[$];
  int m_state = 0;
  int m_coarse = 0;
  bit m_vld = 0;
  int m_fine = 0;
  int m_crs = 0;
  bit m_sat = 0;
  bit m_ovf = 0;

  function automatic logic [N-1:0] m_filter(input logic [N-1:0] t);
    logic [N-1:0] r;
`ifdef TDC_BUBBLE_FILTER_EN
    for (int i = 0; i < N; i++) begin
      int lo, hi, s;
      lo = (i == 0) ? 1 : int'(t[i-1]);
      hi = (i == N-1) ? 0 : int'(t[i+1]);
      s = lo + int'(t[i]) + hi;
      r[i] = (s >= 2);
    end
`else
    r = t;
`endif
    return r;
  endfunction

  task automatic model_edge(input logic c, input logic e, input logic [N-1:0] t, input logic r);
    logic [N-1:0] f;
    bit xfer, arr;
    pend_t p;
    if (c) begin
      m_state = 0; m_coarse = 0; m_vld = 0; m_fine = 0; m_crs = 0; m_sat = 0; m_ovf = 0;
      pq.delete();
      return;
    end
    xfer = m_vld && r;
    arr = 0;
    if (e) begin
      foreach (pq[i]) pq[i].rem--;
      if (pq.size() > 0 && pq[0].rem == 0) begin
        p = pq.pop_front();
        arr = 1;
      end
    end
    if (arr) begin
      if (!m_vld || r) begin
        m_vld = 1; m_fine = p.fine; m_crs = p.crs; m_sat = p.sat;
      end else begin
        m_ovf = 1;
      end
    end else if (xfer) begin
      m_vld = 0;
    end
    if (e) begin
      f = m_filter(t);
      case (m_state)
        0: if (t == '0) m_state = 1;
        1: if (f[0]) begin
             p.rem = 2; p.fine = $countones(f); p.crs = m_coarse; p.sat = (p.fine == N);
             pq.push_back(p);
             m_state = 2;
           end
        default: if (t == '0) m_state = 1;
      endcase
      m_coarse = (m_coarse + 1) & ((1 << CW) - 1);
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, advance the model, compare DUT against it.
  task automatic step(input logic c, input logic e, input logic [N-1:0] t, input logic r);
    clear = c; enable = e; therm = t; out_ready = r;
    @(posedge clk);
    model_edge(c, e, t, r);
    #1;
    check("state", 64'(state), 64'(m_state));
    check("out_valid", 64'(out_valid), 64'(m_vld));
    check("overflow", 64'(overflow), 64'(m_ovf));
    if (m_vld) begin
      check("out_fine", 64'(out_fine), 64'(m_fine));
      check("out_coarse", 64'(out_coarse), 64'(m_crs));
      check("out_sat", 64'(out_sat), 64'(m_sat));
    end
  endtask

  typedef struct packed {
    logic clr; logic en; logic [N-1:0] th; logic rdy;
    logic [1:0] st; logic vld; logic ovf;
    logic dchk; logic [FW-1:0] fine; logic [CW-1:0] crs; logic sat;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(input logic clr, input logic [N-1:0] th, input logic [1:0] st,
                              input logic vld, input logic dchk, input int fine,
                              input int crs, input logic sat);
    vec_t v;
    v.clr = clr; v.en = 1'b1; v.th = th; v.rdy = 1'b1;
    v.st = st; v.vld = vld; v.ovf = 1'b0;
    v.dchk = dchk; v.fine = FW'(fine); v.crs = CW'(crs); v.sat = sat;
    return v;
  endfunction

  initial begin
    logic [N-1:0] t;
    logic [N-1:0] ones;
    int k, n;

    vt.push_back(mk(1, 32'h0,        0, 0, 1, 0,  0, 0));
    vt.push_back(mk(0, 32'h0,        1, 0, 0, 0,  0, 0));
    vt.push_back(mk(0, 32'h0,        1, 0, 0, 0,  0, 0));
    vt.push_back(mk(0, 32'h0,        1, 0, 0, 0,  0, 0));
    vt.push_back(mk(0, 32'h0,        1, 0, 0, 0,  0, 0));
    vt.push_back(mk(0, 32'h0,        1, 0, 0, 0,  0, 0));
    vt.push_back(mk(0, 32'h000000FF, 2, 0, 0, 0,  0, 0));
    vt.push_back(mk(0, 32'h0,        1, 0, 0, 0,  0, 0));
    vt.push_back(mk(0, 32'h0,        1, 1, 1, 8,  5, 0));
    vt.push_back(mk(0, 32'h0,        1, 0, 0, 0,  0, 0));
    vt.push_back(mk(0, 32'hFFFFFFFF, 2, 0, 0, 0,  0, 0));
    vt.push_back(mk(0, 32'h0000FFFF, 2, 0, 0, 0,  0, 0));
    vt.push_back(mk(0, 32'h0000FFFF, 2, 1, 1, 32, 9, 1));
    vt.push_back(mk(0, 32'h0000FFFF, 2, 0, 0, 0,  0, 0));
    vt.push_back(mk(0, 32'h0000FFFF, 2, 0, 0, 0,  0, 0));
    vt.push_back(mk(0, 32'h0,        1, 0, 0, 0,  0, 0));
    vt.push_back(mk(0, 32'h0,        1, 0, 0, 0,  0, 0));
    vt.push_back(mk(0, 32'h000000F7, 2, 0, 0, 0,  0, 0));
    vt.push_back(mk(0, 32'h0,        1, 0, 0, 0,  0, 0));
    vt.push_back(mk(0, 32'h0,        1, 1, 1, BUB_FINE, 16, 0));
    vt.push_back(mk(0, 32'h0,        1, 0, 0, 0,  0, 0));

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].clr, vt[i].en, vt[i].th, vt[i].rdy);
      check($sformatf("vec%0d_state", i), 64'(state), 64'(vt[i].st));
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vt[i].vld));
      check($sformatf("vec%0d_overflow", i), 64'(overflow), 64'(vt[i].ovf));
      if (vt[i].dchk) begin
        check($sformatf("vec%0d_fine", i), 64'(out_fine), 64'(vt[i].fine));
        check($sformatf("vec%0d_coarse", i), 64'(out_coarse), 64'(vt[i].crs));
        check($sformatf("vec%0d_sat", i), 64'(out_sat), 64'(vt[i].sat));
      end
    end

    // Back-pressure: second result collides with the held one
    step(0, 1, 32'h0000000F, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 32'h0, 0);
    step(0, 1, 32'h0000003F, 0);
    step(0, 1, 32'h0, 0);
    step(0, 1, 32'h0, 0);
    check("ovf_held_valid", 64'(out_valid), 64'd1);
    check("ovf_held_fine", 64'(out_fine), 64'd4);
    check("ovf_held_coarse", 64'(out_coarse), 64'd20);
    check("ovf_set", 64'(overflow), 64'd1);
    step(0, 0, 32'h0, 1);
    check("ovf_xfer_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 32'h0, 1);
    check("ovf_sticky", 64'(overflow), 64'd1);
    check("ovf_no_second", 64'(out_valid), 64'd0);
    step(1, 1, 32'h0, 1);
    check("ovf_cleared", 64'(overflow), 64'd0);

    // Clear one cycle after a hit discards it
    step(0, 1, 32'h0, 1);
    step(0, 1, 32'h000000FF, 1);
    step(1, 1, 32'h0, 1);
    check("clr_state", 64'(state), 64'd0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 32'h0, 1);
      check("clr_no_valid", 64'(out_valid), 64'd0);
    end

    // Coarse counter wrap
    for (int i = 6; i < 65535; i++) step(0, 1, 32'h0, 1);
    step(0, 1, 32'h000000FF, 1);
    step(0, 1, 32'h0, 1);
    step(0, 1, 32'h00000003, 1);
    check("wrap_valid_hi", 64'(out_valid), 64'd1);
    check("wrap_coarse_hi", 64'(out_coarse), 64'hFFFF);
    step(0, 1, 32'h0, 1);
    step(0, 1, 32'h0, 1);
    check("wrap_valid_lo", 64'(out_valid), 64'd1);
    check("wrap_coarse_lo", 64'(out_coarse), 64'd1);

    // Random traffic against the model
    ones = '1;
    for (int i = 0; i < 1500; i++) begin
      k = $urandom_range(0, 5);
      n = $urandom_range(0, N);
      case (k)
        1: t = ones >> (N - n);
        2: t = ones;
        3: t = (ones >> (N - n)) ^ (N'(1) << $urandom_range(0, N-1));
        4: t = N'($urandom);
        default: t = '0;
      endcase
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, t, $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
